// File: rtl/cmd_frame_decoder_pkg.sv
// Shared definitions for the command-frame decoder.
// Contents:
//   OPC_*          frame opcodes recognised in IDLE
//   state_t        decoder FSM state encoding
//   OPER_*_ADDR    register-file addresses that receive ALU operands A and B
//   is_timed()     true for the states in which the inter-byte timeout runs
package cmd_frame_decoder_pkg;

  localparam logic [7:0] OPC_WR      = 8'hAA;  // opcode, addr, data
  localparam logic [7:0] OPC_RD      = 8'hBB;  // opcode, addr
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;  // opcode, A, B, fun
  localparam logic [7:0] OPC_ALU_FUN = 8'hDD;  // opcode, fun

  localparam int OPER_A_ADDR = 0;
  localparam int OPER_B_ADDR = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    OP_A,
    OP_B,
    ALU_FUN,
    WAIT_RESP
  } state_t;

  // States that sit in the middle of a frame waiting for the next byte.
  function automatic logic is_timed(state_t s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) ||
           (s == OP_A) || (s == OP_B) || (s == ALU_FUN);
  endfunction

endpackage

// File: rtl/cmd_frame_decoder_if.sv
// Link between the command-frame decoder and its environment.
// Signals:
//   rx_data / rx_data_valid  received byte, qualified by a one-cycle pulse
//   resp_done                one-cycle pulse: TX side has sent the response
//   rf_addr / rf_wr_data / rf_wr_en / rf_rd_en   register-file access
//   alu_fun / alu_en / clk_gate_en               ALU control
//   busy / frame_err         status
//   state                    debug view of the decoder FSM
// Handshake: there is no backpressure anywhere. rx_data_valid and resp_done
// are single-cycle pulses that are always taken in the cycle they are high;
// every strobe the decoder drives (rf_wr_en, rf_rd_en, alu_en, frame_err) is
// a single-cycle pulse the consumer must take in that cycle.
// Modports: master = decoder side, slave = environment side.
interface cmd_frame_decoder_if
  import cmd_frame_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_data_valid;
  logic                  resp_done;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic                  rf_wr_en;
  logic                  rf_rd_en;
  logic [FUN_WIDTH-1:0]  alu_fun;
  logic                  alu_en;
  logic                  clk_gate_en;
  logic                  busy;
  logic                  frame_err;
  state_t                state;

  modport master (
    input  rx_data, rx_data_valid, resp_done,
    output rf_addr, rf_wr_data, rf_wr_en, rf_rd_en,
    output alu_fun, alu_en, clk_gate_en, busy, frame_err, state
  );

  modport slave (
    output rx_data, rx_data_valid, resp_done,
    input  rf_addr, rf_wr_data, rf_wr_en, rf_rd_en,
    input  alu_fun, alu_en, clk_gate_en, busy, frame_err, state
  );
endinterface

// File: rtl/cmd_frame_decoder_frame_timer.sv
// Inter-byte timeout counter.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   en        count while high
//   clr       synchronous clear, wins over en
//   expired   high while enabled and the count sits at TIMEOUT_CYCLES-1
module cmd_frame_decoder_frame_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      // Holds at LAST so a stalled consumer never sees a wrapped count.
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LAST);
endmodule

// File: rtl/cmd_frame_decoder.sv
// Command-frame parser sitting behind the RX byte synchronizer.
// Decodes write / read / ALU frames into register-file and ALU strobes,
// holds busy until the TX side reports the response sent, and aborts a
// frame that stalls for TIMEOUT_CYCLES between bytes.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   decoder side (master) of cmd_frame_decoder_if
// All outputs are registered: a strobe appears in the cycle after the
// rx_data_valid pulse that completes its step.
module cmd_frame_decoder
  import cmd_frame_decoder_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  cmd_frame_decoder_if.master bus
);
  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nx;
  logic [FUN_WIDTH-1:0]  fun_q, fun_nx;
  logic wr_q, wr_nx, rd_q, rd_nx, alu_q, alu_nx;
  logic gate_q, gate_nx, busy_q, busy_nx, err_q, err_nx;
  logic tmr_en, tmr_clr, expired;

  // Every byte that arrives in a mid-frame state is consumed, so any valid
  // byte there (and any state change) restarts the inter-byte window.
  assign tmr_en  = is_timed(state);
  assign tmr_clr = (bus.rx_data_valid && tmr_en) || (state_nx != state);

  cmd_frame_decoder_frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (tmr_en),
    .clr     (tmr_clr),
    .expired (expired)
  );

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    fun_nx   = fun_q;
    wr_nx    = 1'b0;
    rd_nx    = 1'b0;
    alu_nx   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_data_valid) begin
          case (bus.rx_data)
            OPC_WR:      state_nx = WR_ADDR;
            OPC_RD:      state_nx = RD_ADDR;
            OPC_ALU_OP:  state_nx = OP_A;
            OPC_ALU_FUN: state_nx = ALU_FUN;
            default:     err_nx   = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        if (bus.rx_data_valid) begin
          addr_nx  = bus.rx_data[ADDR_WIDTH-1:0];
          state_nx = WR_DATA;
        end else if (expired) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      WR_DATA: begin
        if (bus.rx_data_valid) begin
          wdata_nx = bus.rx_data;
          wr_nx    = 1'b1;
          state_nx = IDLE;
        end else if (expired) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.rx_data_valid) begin
          addr_nx  = bus.rx_data[ADDR_WIDTH-1:0];
          rd_nx    = 1'b1;
          state_nx = WAIT_RESP;
        end else if (expired) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      OP_A, OP_B: begin
        if (bus.rx_data_valid) begin
          addr_nx  = (state == OP_A) ? ADDR_WIDTH'(OPER_A_ADDR) : ADDR_WIDTH'(OPER_B_ADDR);
          wdata_nx = bus.rx_data;
          wr_nx    = 1'b1;
          state_nx = (state == OP_A) ? OP_B : ALU_FUN;
        end else if (expired) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      ALU_FUN: begin
        if (bus.rx_data_valid) begin
          fun_nx   = bus.rx_data[FUN_WIDTH-1:0];
          alu_nx   = 1'b1;
          state_nx = WAIT_RESP;
        end else if (expired) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT_RESP: begin
        // A byte here is dropped even when resp_done lands in the same cycle.
        if (bus.rx_data_valid) err_nx = 1'b1;
        if (bus.resp_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // The gate opens on entry to ALU_FUN and survives only into the
    // WAIT_RESP of that same ALU command; a read never opens it.
    gate_nx = (state_nx == ALU_FUN) || ((state_nx == WAIT_RESP) && gate_q);
    busy_nx = (state_nx == WAIT_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      fun_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      alu_q   <= 1'b0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      fun_q   <= fun_nx;
      wr_q    <= wr_nx;
      rd_q    <= rd_nx;
      alu_q   <= alu_nx;
      gate_q  <= gate_nx;
      busy_q  <= busy_nx;
      err_q   <= err_nx;
    end
  end

  assign bus.rf_addr     = addr_q;
  assign bus.rf_wr_data  = wdata_q;
  assign bus.rf_wr_en    = wr_q;
  assign bus.rf_rd_en    = rd_q;
  assign bus.alu_fun     = fun_q;
  assign bus.alu_en      = alu_q;
  assign bus.clk_gate_en = gate_q;
  assign bus.busy        = busy_q;
  assign bus.frame_err   = err_q;
  assign bus.state       = state;
endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder (timeout shortened to 16 cycles).
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// so after send_byte() returns the registered response to that byte is visible.
module tb_cmd_frame_decoder;
  import cmd_frame_decoder_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cmd_frame_decoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) bus ();

  cmd_frame_decoder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int w0;

  // Counts rf_wr_en pulses; a pulse is counted at the rising edge that ends it.
  always @(posedge clk) if (bus.rf_wr_en === 1'b1) wr_cnt++;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rf_addr"},     32'(bus.rf_addr),    32'h0);
    chk({tag, ".rf_wr_data"},  32'(bus.rf_wr_data), 32'h0);
    chk({tag, ".rf_wr_en"},    32'(bus.rf_wr_en),   32'h0);
    chk({tag, ".rf_rd_en"},    32'(bus.rf_rd_en),   32'h0);
    chk({tag, ".alu_fun"},     32'(bus.alu_fun),    32'h0);
    chk({tag, ".alu_en"},      32'(bus.alu_en),     32'h0);
    chk({tag, ".clk_gate_en"}, 32'(bus.clk_gate_en), 32'h0);
    chk({tag, ".busy"},        32'(bus.busy),       32'h0);
    chk({tag, ".frame_err"},   32'(bus.frame_err),  32'h0);
    chk({tag, ".state"},       32'(bus.state),      32'(IDLE));
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data       = b;
    bus.rx_data_valid = 1'b1;
    @(negedge clk);
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_resp();
    @(negedge clk);
    bus.resp_done = 1'b1;
    @(negedge clk);
    bus.resp_done = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.rx_data       = '0;
    bus.rx_data_valid = 1'b0;
    bus.resp_done     = 1'b0;
    idle(3);
    chk_zero("reset");
    rst = 1'b1;
    idle(2);

    // Write frame AA,05,3C with 3-cycle gaps
    send_byte(8'hAA);
    chk("wr.state_addr", 32'(bus.state), 32'(WR_ADDR));
    idle(3);
    send_byte(8'h05);
    chk("wr.addr", 32'(bus.rf_addr), 32'h5);
    chk("wr.no_early_strobe", 32'(bus.rf_wr_en), 32'h0);
    chk("wr.state_data", 32'(bus.state), 32'(WR_DATA));
    idle(3);
    send_byte(8'h3C);
    chk("wr.strobe", 32'(bus.rf_wr_en), 32'h1);
    chk("wr.addr_hold", 32'(bus.rf_addr), 32'h5);
    chk("wr.data", 32'(bus.rf_wr_data), 32'h3C);
    chk("wr.busy", 32'(bus.busy), 32'h0);
    chk("wr.state_idle", 32'(bus.state), 32'(IDLE));
    idle(1);
    chk("wr.strobe_one_cycle", 32'(bus.rf_wr_en), 32'h0);

    // Read frame BB,07, busy until resp_done, then write AA,01,FF
    send_byte(8'hBB);
    send_byte(8'h07);
    chk("rd.strobe", 32'(bus.rf_rd_en), 32'h1);
    chk("rd.addr", 32'(bus.rf_addr), 32'h7);
    chk("rd.busy", 32'(bus.busy), 32'h1);
    chk("rd.no_gate", 32'(bus.clk_gate_en), 32'h0);
    idle(1);
    chk("rd.strobe_one_cycle", 32'(bus.rf_rd_en), 32'h0);
    idle(5);
    chk("rd.busy_hold", 32'(bus.busy), 32'h1);
    chk("rd.state_wait", 32'(bus.state), 32'(WAIT_RESP));
    pulse_resp();
    chk("rd.busy_clear", 32'(bus.busy), 32'h0);
    chk("rd.state_idle", 32'(bus.state), 32'(IDLE));
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'hFF);
    chk("rd.next_wr_strobe", 32'(bus.rf_wr_en), 32'h1);
    chk("rd.next_wr_addr", 32'(bus.rf_addr), 32'h1);
    chk("rd.next_wr_data", 32'(bus.rf_wr_data), 32'hFF);

    // ALU frame CC,12,34,02
    send_byte(8'hCC);
    send_byte(8'h12);
    chk("alu.opa_strobe", 32'(bus.rf_wr_en), 32'h1);
    chk("alu.opa_addr", 32'(bus.rf_addr), 32'h0);
    chk("alu.opa_data", 32'(bus.rf_wr_data), 32'h12);
    chk("alu.opa_no_gate", 32'(bus.clk_gate_en), 32'h0);
    send_byte(8'h34);
    chk("alu.opb_strobe", 32'(bus.rf_wr_en), 32'h1);
    chk("alu.opb_addr", 32'(bus.rf_addr), 32'h1);
    chk("alu.opb_data", 32'(bus.rf_wr_data), 32'h34);
    chk("alu.fun_state", 32'(bus.state), 32'(ALU_FUN));
    chk("alu.gate_on_entry", 32'(bus.clk_gate_en), 32'h1);
    send_byte(8'h02);
    chk("alu.en", 32'(bus.alu_en), 32'h1);
    chk("alu.fun", 32'(bus.alu_fun), 32'h2);
    chk("alu.busy", 32'(bus.busy), 32'h1);
    chk("alu.gate_wait", 32'(bus.clk_gate_en), 32'h1);
    chk("alu.no_wr", 32'(bus.rf_wr_en), 32'h0);
    idle(1);
    chk("alu.en_one_cycle", 32'(bus.alu_en), 32'h0);
    @(negedge clk);
    bus.resp_done = 1'b1;
    chk("alu.gate_during_resp", 32'(bus.clk_gate_en), 32'h1);
    @(negedge clk);
    bus.resp_done = 1'b0;
    chk("alu.gate_after_resp", 32'(bus.clk_gate_en), 32'h0);
    chk("alu.busy_after_resp", 32'(bus.busy), 32'h0);

    // DD,03 then a byte while busy, then one coinciding with resp_done
    send_byte(8'hDD);
    chk("busy.fun_state", 32'(bus.state), 32'(ALU_FUN));
    send_byte(8'h03);
    chk("busy.alu_fun", 32'(bus.alu_fun), 32'h3);
    idle(1);
    send_byte(8'h55);
    chk("busy.drop_err", 32'(bus.frame_err), 32'h1);
    chk("busy.drop_state", 32'(bus.state), 32'(WAIT_RESP));
    chk("busy.drop_busy", 32'(bus.busy), 32'h1);
    chk("busy.drop_fun", 32'(bus.alu_fun), 32'h3);
    idle(1);
    chk("busy.err_one_cycle", 32'(bus.frame_err), 32'h0);
    @(negedge clk);
    bus.rx_data       = 8'h55;
    bus.rx_data_valid = 1'b1;
    bus.resp_done     = 1'b1;
    @(negedge clk);
    bus.rx_data_valid = 1'b0;
    bus.resp_done     = 1'b0;
    chk("coinc.err", 32'(bus.frame_err), 32'h1);
    chk("coinc.state", 32'(bus.state), 32'(IDLE));
    chk("coinc.busy", 32'(bus.busy), 32'h0);
    chk("coinc.gate", 32'(bus.clk_gate_en), 32'h0);
    send_byte(8'hBB);
    chk("coinc.next_accepted", 32'(bus.state), 32'(RD_ADDR));
    send_byte(8'hF3);
    chk("coinc.addr_upper_ignored", 32'(bus.rf_addr), 32'h3);
    chk("coinc.addr_no_err", 32'(bus.frame_err), 32'h0);
    pulse_resp();

    // Timeout: AA,05 then silence
    w0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h05);
    idle(TO - 1);
    chk("to.before_expiry_err", 32'(bus.frame_err), 32'h0);
    chk("to.before_expiry_state", 32'(bus.state), 32'(WR_DATA));
    idle(1);
    chk("to.err", 32'(bus.frame_err), 32'h1);
    chk("to.state", 32'(bus.state), 32'(IDLE));
    chk("to.no_wr", 32'(bus.rf_wr_en), 32'h0);
    idle(1);
    chk("to.err_one_cycle", 32'(bus.frame_err), 32'h0);
    chk("to.no_wr_count", 32'(wr_cnt), 32'(w0));

    // Byte in the expiry cycle is consumed
    send_byte(8'hAA);
    send_byte(8'h05);
    idle(TO - 2);
    send_byte(8'h77);
    chk("to_win.strobe", 32'(bus.rf_wr_en), 32'h1);
    chk("to_win.data", 32'(bus.rf_wr_data), 32'h77);
    chk("to_win.no_err", 32'(bus.frame_err), 32'h0);
    chk("to_win.state", 32'(bus.state), 32'(IDLE));
    idle(1);
    chk("to_win.wr_count", 32'(wr_cnt), 32'(w0 + 1));

    // Timeout in ALU_FUN closes the clock gate
    send_byte(8'hDD);
    idle(TO - 1);
    chk("to_fun.gate_hold", 32'(bus.clk_gate_en), 32'h1);
    idle(1);
    chk("to_fun.err", 32'(bus.frame_err), 32'h1);
    chk("to_fun.gate_clear", 32'(bus.clk_gate_en), 32'h0);
    chk("to_fun.no_alu_en", 32'(bus.alu_en), 32'h0);
    chk("to_fun.state", 32'(bus.state), 32'(IDLE));

    // Illegal opcode
    send_byte(8'h99);
    chk("illegal.err", 32'(bus.frame_err), 32'h1);
    chk("illegal.state", 32'(bus.state), 32'(IDLE));
    idle(1);
    chk("illegal.err_one_cycle", 32'(bus.frame_err), 32'h0);

    // Reset asserted while in OP_B, then DD,01
    send_byte(8'hCC);
    send_byte(8'h11);
    chk("rst.in_opb", 32'(bus.state), 32'(OP_B));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'hDD);
    send_byte(8'h01);
    chk("rst.after_alu_en", 32'(bus.alu_en), 32'h1);
    chk("rst.after_alu_fun", 32'(bus.alu_fun), 32'h1);
    chk("rst.after_busy", 32'(bus.busy), 32'h1);
    pulse_resp();
    chk("rst.after_idle", 32'(bus.state), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cmd_frame_decoder.md
Name: cmd_frame_decoder

Overview:
- Command-frame parser that sits directly downstream of the RX-domain data synchronizer.
- Consumes synchronized UART bytes, each qualified by a one-cycle valid pulse.
- Decodes the command frames and drives register-file write/read strobes, ALU operand writes and ALU function/enable.
- Holds a busy interlock until the TX side reports that the response has been sent.

Parameters:
- DATA_WIDTH, 8, width of received bytes and register data.
- ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte.
- FUN_WIDTH, 4, ALU function code width; taken from the low bits of the function byte.
- TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- rx_data  in  DATA_WIDTH  synchronized received byte.
- rx_data_valid  in  1  one-cycle pulse; rx_data is valid in the same cycle.
- resp_done  in  1  one-cycle pulse from the TX side; the response for the current read/ALU command has been sent.
- rf_addr  out  ADDR_WIDTH  register-file address.
- rf_wr_data  out  DATA_WIDTH  register-file write data.
- rf_wr_en  out  1  one-cycle write strobe.
- rf_rd_en  out  1  one-cycle read strobe.
- alu_fun  out  FUN_WIDTH  ALU function code.
- alu_en  out  1  one-cycle ALU start strobe.
- clk_gate_en  out  1  ALU clock-gate enable.
- busy  out  1  high while waiting for resp_done.
- frame_err  out  1  one-cycle error pulse.

Behaviour:
- One clock domain (clk). rst is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Reset asserted mid-frame aborts the frame immediately; no strobe is issued.
- Opcodes:
  - 0xAA: register write. Frame = opcode, addr, data.
  - 0xBB: register read. Frame = opcode, addr.
  - 0xCC: ALU with operands. Frame = opcode, A, B, fun.
  - 0xDD: ALU without operands. Frame = opcode, fun.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN, WAIT_RESP.
- All outputs are registered. Any strobe appears in the cycle after the rx_data_valid pulse that completes its step.
- IDLE transitions on a byte:
  - 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> OP_A; 0xDD -> ALU_FUN.
  - Any other byte: frame_err pulse, remain in IDLE.
- WR_ADDR: latch rf_addr = byte[ADDR_WIDTH-1:0] -> WR_DATA.
- WR_DATA: rf_wr_data = byte; rf_wr_en pulses 1 cycle -> IDLE. A write produces no response.
- RD_ADDR: rf_addr latched; rf_rd_en pulses 1 cycle -> WAIT_RESP.
- OP_A: rf_addr = 0, rf_wr_data = byte, rf_wr_en pulse -> OP_B.
- OP_B: same with rf_addr = 1 -> ALU_FUN.
- ALU_FUN: alu_fun = byte[FUN_WIDTH-1:0]; alu_en pulses 1 cycle -> WAIT_RESP.
- clk_gate_en:
  - Set on entry to ALU_FUN.
  - Held through WAIT_RESP of an ALU command.
  - Cleared on the cycle after resp_done.
- busy: high in WAIT_RESP only.
- WAIT_RESP exits to IDLE on resp_done.
  - A byte arriving in WAIT_RESP is dropped and pulses frame_err. This also applies when it arrives in the same cycle as resp_done.
  - The first byte after returning to IDLE is accepted normally.
- Timeout:
  - The counter runs only in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and ALU_FUN.
  - It clears on every accepted byte and on every state change.
  - On reaching TIMEOUT_CYCLES-1: frame_err pulse, go to IDLE, no strobe issued, clk_gate_en cleared.
  - A byte arriving in the expiry cycle wins: it is consumed and the counter clears.
- Operand writes already issued in OP_A/OP_B are not rolled back by a later timeout.
- Address/function bytes: upper bits are ignored, no error.
- rf_addr, rf_wr_data and alu_fun hold their last values between strobes.

Decomposition:
- Shared package holds:
  - the opcode constants (0xAA, 0xBB, 0xCC, 0xDD);
  - the state encoding;
  - the operand register addresses (A = 0, B = 1).
- One sub-module, frame_timer: the clearable/enabled timeout counter, width $clog2(TIMEOUT_CYCLES), with an expiry pulse output.
- The FSM and output registers stay in cmd_frame_decoder.

Test Plan:
- Write frame: bytes AA,05,3C, gaps of 3 cycles -> single rf_wr_en pulse with rf_addr=5, rf_wr_data=0x3C, one cycle after the 3C valid; busy stays 0.
- Read frame: BB,07 -> rf_rd_en pulse with rf_addr=7; busy=1 until resp_done; the next frame AA,01,FF is accepted afterwards.
- ALU frame: CC,12,34,02 -> rf_wr_en (addr0=0x12), then rf_wr_en (addr1=0x34), then alu_en with alu_fun=2; clk_gate_en high from fun-state entry until the cycle after resp_done.
- Byte during busy: DD,03 then byte 55 while busy -> frame_err pulse, no state change. Repeat with 55 coinciding with resp_done -> dropped, IDLE reached.
- Timeout: TIMEOUT_CYCLES=16; send AA,05 then silence -> frame_err and IDLE 15 cycles after the last accepted byte, no rf_wr_en. Byte on the expiry cycle -> accepted as data, write issued.
- Illegal opcode 0x99 in IDLE -> frame_err, remain IDLE. Reset asserted in OP_B -> all outputs 0, and a following DD,01 works.
